// File: rtl/mem_1r1w_banked.sv
// Banked 1R1W memory: DEPTH x WIDTH tiled onto MACRO_DEPTH-row banks, masked writes, post-reset clear.
// Optional write-to-read forwarding on same-address collisions is enabled by defining MEM_1R1W_FWD_EN.
module mem_1r1w_banked #(
    parameter int unsigned DEPTH       = 48,
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned MACRO_DEPTH = 32,
    parameter int unsigned MASK_GRAN   = 16,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned NL = WIDTH / MASK_GRAN
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    R0_addr,
    input  logic             R0_en,
    output logic [WIDTH-1:0] R0_data,
    input  logic [AW-1:0]    W0_addr,
    input  logic             W0_en,
    input  logic [WIDTH-1:0] W0_data,
    input  logic [NL-1:0]    W0_mask,
    output logic             init_busy
);
    localparam int unsigned NB = (DEPTH + MACRO_DEPTH - 1) / MACRO_DEPTH;
    localparam int unsigned RB = $clog2(MACRO_DEPTH);
    localparam int unsigned EW = (AW > RB) ? AW : RB;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t          r_state, w_state_nxt;
    logic [RB-1:0]   r_cnt, w_cnt_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == S_CLEAR) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == RB'(MACRO_DEPTH - 1)) w_state_nxt = S_READY;
        end
    end

    assign init_busy = (r_state != S_READY);

    // Address split: zero-extend so the row slice is legal even when AW < RB.
    logic [EW-1:0] w_raddr_x, w_waddr_x, w_rbank, w_wbank;
    logic [RB-1:0] w_rrow, w_wrow;
    logic          w_rin, w_win, w_racc, w_wacc;

    assign w_raddr_x = EW'(R0_addr);
    assign w_waddr_x = EW'(W0_addr);
    assign w_rrow    = w_raddr_x[RB-1:0];
    assign w_wrow    = w_waddr_x[RB-1:0];
    assign w_rbank   = w_raddr_x >> RB;
    assign w_wbank   = w_waddr_x >> RB;
    assign w_rin     = (32'(R0_addr) < DEPTH);
    assign w_win     = (32'(W0_addr) < DEPTH);
    assign w_racc    = R0_en && !init_busy;
    assign w_wacc    = W0_en && !init_busy && w_win;

    logic [WIDTH-1:0] w_bank_q [NB];

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [WIDTH-1:0] r_mem [MACRO_DEPTH];
        logic [WIDTH-1:0] r_q_p1;
        logic             w_we, w_re;

        assign w_we = w_wacc && (w_wbank == EW'(b));
        assign w_re = w_racc && w_rin && (w_rbank == EW'(b));

        always_ff @(posedge clock) begin
            if (init_busy) begin
                r_mem[r_cnt] <= '0;
            end else if (w_we) begin
                for (int l = 0; l < NL; l++) begin
                    if (W0_mask[l]) r_mem[w_wrow][l*MASK_GRAN +: MASK_GRAN] <= W0_data[l*MASK_GRAN +: MASK_GRAN];
                end
            end
            if (w_re) r_q_p1 <= r_mem[w_rrow];
        end

        assign w_bank_q[b] = r_q_p1;
    end

    // Stage p1: bank select and in-range flag travel with the bank read.
    logic          r_rd_ok_p1;
    logic [BW-1:0] r_rd_bank_p1;

    always_ff @(posedge clock) begin
        if (reset)       r_rd_ok_p1 <= 1'b0;
        else if (w_racc) r_rd_ok_p1 <= w_rin;
    end

    always_ff @(posedge clock) begin
        if (w_racc) r_rd_bank_p1 <= BW'(w_rbank);
    end

`ifdef MEM_1R1W_FWD_EN
    logic             r_fwd_hit_p1;
    logic [WIDTH-1:0] r_fwd_data_p1;
    logic [NL-1:0]    r_fwd_mask_p1;

    always_ff @(posedge clock) begin
        if (reset)       r_fwd_hit_p1 <= 1'b0;
        else if (w_racc) r_fwd_hit_p1 <= w_wacc && (R0_addr == W0_addr);
    end

    always_ff @(posedge clock) begin
        if (w_racc) begin
            r_fwd_data_p1 <= W0_data;
            r_fwd_mask_p1 <= W0_mask;
        end
    end
`endif

    logic [WIDTH-1:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        if (r_rd_ok_p1) w_rdata = w_bank_q[r_rd_bank_p1];
`ifdef MEM_1R1W_FWD_EN
        if (r_rd_ok_p1 && r_fwd_hit_p1) begin
            for (int l = 0; l < NL; l++) begin
                if (r_fwd_mask_p1[l]) w_rdata[l*MASK_GRAN +: MASK_GRAN] = r_fwd_data_p1[l*MASK_GRAN +: MASK_GRAN];
            end
        end
`endif
    end

    assign R0_data = w_rdata;

endmodule

// File: tb/tb_mem_1r1w_banked.sv
// Bench for mem_1r1w_banked (default geometry): directed vector table, reset/clear sequences,
// and randomized traffic against an array-based reference model.
module tb_mem_1r1w_banked;
    localparam int DEPTH = 48;
    localparam int AW    = 6;
    localparam int NL    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] R0_addr = '0;
    logic          R0_en = 1'b0;
    logic [63:0]   R0_data;
    logic [AW-1:0] W0_addr = '0;
    logic          W0_en = 1'b0;
    logic [63:0]   W0_data = '0;
    logic [NL-1:0] W0_mask = '0;
    logic          init_busy;

    mem_1r1w_banked dut (
        .clock(clock), .reset(reset),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
        .init_busy(init_busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [63:0] mdl [DEPTH];
    logic [63:0] mexp;

    typedef struct {
        logic          ren;
        logic [AW-1:0] raddr;
        logic          wen;
        logic [AW-1:0] waddr;
        logic [63:0]   wdata;
        logic [3:0]    wmask;
        logic          chk;
        logic [63:0]   exp;
    } vec_t;

    vec_t vecs [22];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lane_bits(input logic [3:0] m);
        logic [63:0] r;
        for (int l = 0; l < 4; l++) r[l*16 +: 16] = {16{m[l]}};
        return r;
    endfunction

    task automatic idle;
        R0_en = 1'b0; W0_en = 1'b0; W0_mask = '0; W0_data = '0;
    endtask

    task automatic model_clear;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        mexp = '0;
    endtask

    // Called with reset just released; counts cycles until init_busy drops.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (init_busy && n < 200) begin
            tick;
            n++;
        end
        check(name, 64'(n), 64'd32);
    endtask

    task automatic cyc(input logic ren, input logic [AW-1:0] raddr, input logic wen,
                       input logic [AW-1:0] waddr, input logic [63:0] wdata, input logic [3:0] wmask);
        logic [63:0] lm, rd;
        R0_en = ren; R0_addr = raddr; W0_en = wen; W0_addr = waddr; W0_data = wdata; W0_mask = wmask;
        tick;
        lm = lane_bits(wmask);
        if (ren) begin
            rd = '0;
            if (int'(raddr) < DEPTH) begin
                rd = mdl[raddr];
`ifdef MEM_1R1W_FWD_EN
                if (wen && waddr == raddr) rd = (rd & ~lm) | (wdata & lm);
`endif
            end
            mexp = rd;
        end
        if (wen && int'(waddr) < DEPTH) mdl[waddr] = (mdl[waddr] & ~lm) | (wdata & lm);
        check("rand_rdata", R0_data, mexp);
    endtask

    function automatic vec_t mk(input logic ren, input int ra, input logic wen, input int wa,
                                input logic [63:0] wd, input logic [3:0] wm, input logic chk,
                                input logic [63:0] exp);
        vec_t v;
        v.ren = ren; v.raddr = AW'(ra); v.wen = wen; v.waddr = AW'(wa);
        v.wdata = wd; v.wmask = wm; v.chk = chk; v.exp = exp;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(1, 0,  0, 0,  64'h0, 4'h0, 1, 64'h0);
        vecs[1]  = mk(1, 31, 0, 0,  64'h0, 4'h0, 1, 64'h0);
        vecs[2]  = mk(1, 32, 0, 0,  64'h0, 4'h0, 1, 64'h0);
        vecs[3]  = mk(1, 47, 0, 0,  64'h0, 4'h0, 1, 64'h0);
        vecs[4]  = mk(0, 0,  1, 5,  64'h1111_1111_1111_1111, 4'hF, 0, 64'h0);
        vecs[5]  = mk(0, 0,  1, 37, 64'h2222_2222_2222_2222, 4'hF, 0, 64'h0);
        vecs[6]  = mk(1, 5,  0, 0,  64'h0, 4'h0, 1, 64'h1111_1111_1111_1111);
        vecs[7]  = mk(1, 37, 0, 0,  64'h0, 4'h0, 1, 64'h2222_2222_2222_2222);
        vecs[8]  = mk(0, 5,  0, 0,  64'h0, 4'h0, 1, 64'h2222_2222_2222_2222);
        vecs[9]  = mk(0, 0,  1, 40, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 0, 64'h0);
        vecs[10] = mk(0, 0,  1, 40, 64'h0, 4'b0101, 0, 64'h0);
        vecs[11] = mk(1, 40, 0, 0,  64'h0, 4'h0, 1, 64'hFFFF_0000_FFFF_0000);
        vecs[12] = mk(0, 0,  1, 50, 64'hABCD, 4'hF, 0, 64'h0);
        vecs[13] = mk(1, 50, 0, 0,  64'h0, 4'h0, 1, 64'h0);
        vecs[14] = mk(1, 18, 0, 0,  64'h0, 4'h0, 1, 64'h0);
        vecs[15] = mk(0, 0,  1, 10, 64'hAAAA_AAAA_AAAA_AAAA, 4'hF, 0, 64'h0);
`ifdef MEM_1R1W_FWD_EN
        vecs[16] = mk(1, 10, 1, 10, 64'h5555_5555_5555_5555, 4'b0011, 1, 64'hAAAA_AAAA_5555_5555);
`else
        vecs[16] = mk(1, 10, 1, 10, 64'h5555_5555_5555_5555, 4'b0011, 1, 64'hAAAA_AAAA_AAAA_AAAA);
`endif
        vecs[17] = mk(1, 10, 0, 0,  64'h0, 4'h0, 1, 64'hAAAA_AAAA_5555_5555);
        vecs[18] = mk(1, 5,  1, 5,  64'h0, 4'h0, 1, 64'h1111_1111_1111_1111);
        vecs[19] = mk(0, 0,  1, 63, 64'hDEAD_BEEF_DEAD_BEEF, 4'hF, 0, 64'h0);
        vecs[20] = mk(1, 63, 0, 0,  64'h0, 4'h0, 1, 64'h0);
        vecs[21] = mk(1, 37, 0, 0,  64'h0, 4'h0, 1, 64'h2222_2222_2222_2222);

        idle;
        reset = 1'b1;
        repeat (3) tick;
        check("rst_busy", 64'(init_busy), 64'd1);
        check("rst_rdata", R0_data, 64'h0);

        reset = 1'b0;
        R0_en = 1'b1; R0_addr = 6'd3;
        W0_en = 1'b1; W0_addr = 6'd3; W0_data = '1; W0_mask = 4'hF;
        wait_ready("busy_len");
        idle;
        check("busy_rdata", R0_data, 64'h0);

        for (int i = 0; i < 22; i++) begin
            R0_en = vecs[i].ren; R0_addr = vecs[i].raddr;
            W0_en = vecs[i].wen; W0_addr = vecs[i].waddr;
            W0_data = vecs[i].wdata; W0_mask = vecs[i].wmask;
            tick;
            if (vecs[i].chk) check($sformatf("vec%0d", i), R0_data, vecs[i].exp);
        end
        idle;

        // Reset from READY, then again part-way through the clear walk.
        reset = 1'b1;
        tick;
        check("rst_from_ready_rdata", R0_data, 64'h0);
        check("rst_from_ready_busy", 64'(init_busy), 64'd1);
        reset = 1'b0;
        repeat (10) tick;
        check("mid_clear_busy", 64'(init_busy), 64'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        W0_en = 1'b1; W0_addr = 6'd7; W0_data = '1; W0_mask = 4'hF;
        wait_ready("busy_len_mid_reset");
        idle;
        model_clear;

        cyc(1, 6'd7,  0, 6'd0, 64'h0, 4'h0);
        cyc(1, 6'd5,  0, 6'd0, 64'h0, 4'h0);
        cyc(1, 6'd40, 0, 6'd0, 64'h0, 4'h0);

        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] ra, wa;
            ra = AW'($urandom_range(0, 63));
            wa = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, 63));
            cyc(1'($urandom_range(0, 2) != 0), ra, 1'($urandom_range(0, 1)), wa,
                {$urandom, $urandom}, 4'($urandom_range(0, 15)));
        end
        idle;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
